// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/result pipeline feeding a 16-bit ALU, with result chaining.
// Optional divide-by-zero guard: define ALU_DIVZERO_GUARD_EN.
module alu_cmd_sequencer #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          clear,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [3:0]    cmd_opcode,
   input  logic [W-1:0]  cmd_a,
   input  logic [W-1:0]  cmd_b,
   input  logic          cmd_chain,
   output logic [W-1:0]  alu_input1,
   output logic [W-1:0]  alu_input2,
   output logic [3:0]    alu_opcode,
   input  logic [W-1:0]  alu_out,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic [3:0]    res_opcode,
`ifdef ALU_DIVZERO_GUARD_EN
   output logic          err_divzero,
`endif
   output logic [CW-1:0] fifo_count,
   output logic          busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0] OP_NOOP  = 4'd0;
`ifdef ALU_DIVZERO_GUARD_EN
   localparam logic [3:0] OP_DIV   = 4'd4;
   localparam logic [3:0] OP_RESET = 4'd15;
`endif

   typedef struct packed {
      logic [3:0]   opcode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         chain;
   } cmd_t;

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   cmd_t          iss;
   logic          iss_valid;
   logic [W-1:0]  last_result;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic adv_res;

   assign full       = (count == CW'(DEPTH));
   assign empty      = (count == '0);
   assign cmd_ready  = !full;
   assign push       = cmd_valid && !full;
   assign adv_res    = iss_valid && (!res_valid || res_ready);
   assign pop        = !empty && (!iss_valid || adv_res);
   assign fifo_count = count;
   assign busy       = !empty || iss_valid || res_valid;

`ifdef ALU_DIVZERO_GUARD_EN
   logic div_zero;
   assign div_zero = (iss.opcode == OP_DIV) && (iss.b == '0);
`endif

   // FIFO storage; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr] <= '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, chain: cmd_chain};
      end
   end

   // FIFO pointers/count and issue register
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         iss       <= '0;
         iss_valid <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (pop) begin
            iss       <= mem[rd_ptr];
            iss_valid <= 1'b1;
         end else if (adv_res) begin
            iss_valid <= 1'b0;
         end
      end
   end

   // Result register; last_result feeds chained commands
   always_ff @(posedge clk) begin
      if (clear) begin
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_opcode  <= '0;
         last_result <= '0;
`ifdef ALU_DIVZERO_GUARD_EN
         err_divzero <= 1'b0;
`endif
      end else if (adv_res) begin
         res_valid   <= 1'b1;
         res_data    <= alu_out;
         res_opcode  <= iss.opcode;
         last_result <= alu_out;
`ifdef ALU_DIVZERO_GUARD_EN
         err_divzero <= div_zero;
`endif
      end else if (res_valid && res_ready) begin
         res_valid <= 1'b0;
      end
   end

   // ALU drive: idle shows NOOP with zero operands; a held issue keeps inputs stable
   always_comb begin
      alu_opcode = OP_NOOP;
      alu_input1 = '0;
      alu_input2 = '0;
      if (iss_valid) begin
         alu_opcode = iss.opcode;
         alu_input2 = iss.b;
         alu_input1 = iss.chain ? last_result : iss.a;
`ifdef ALU_DIVZERO_GUARD_EN
         if (div_zero) begin
            alu_opcode = OP_RESET;
         end
`endif
      end
   end

endmodule
